// File: rtl/qp_patch_loader.sv
// Query patch loader: packs WORDS_PER_PATCH words from a first-word-fall-through FIFO
// into one wide patch and writes NUM_QUERYS patches to consecutive query memory addresses.
module qp_patch_loader #(
    parameter int DATA_WIDTH      = 11,
    parameter int WORDS_PER_PATCH = 5,
    parameter int ADDR_WIDTH      = 9,
    parameter int NUM_QUERYS      = 512
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [DATA_WIDTH-1:0]                 in_fifo_rdata,
    input  logic                                  in_fifo_rempty_n,
    output logic                                  in_fifo_deq,
    output logic                                  qp_mem_csb0,
    output logic                                  qp_mem_web0,
    output logic [ADDR_WIDTH-1:0]                 qp_mem_addr0,
    output logic [DATA_WIDTH*WORDS_PER_PATCH-1:0] qp_mem_wpatch0,
    output logic                                  busy,
    output logic                                  load_done
);

    localparam int PATCH_WIDTH = DATA_WIDTH * WORDS_PER_PATCH;
    localparam int WCNT_WIDTH  = (WORDS_PER_PATCH > 1) ? $clog2(WORDS_PER_PATCH) : 1;
    localparam logic [WCNT_WIDTH-1:0] LAST_WORD  = WCNT_WIDTH'(WORDS_PER_PATCH - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_PATCH = ADDR_WIDTH'(NUM_QUERYS - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        DONE
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [WCNT_WIDTH-1:0]   word_cnt_q;
    logic [ADDR_WIDTH-1:0]   patch_cnt_q;
    logic [PATCH_WIDTH-1:0]  patch_q;
    logic                    last_word;
    logic                    last_patch;

    assign last_word  = (word_cnt_q == LAST_WORD);
    assign last_patch = (patch_cnt_q == LAST_PATCH);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d        = state_q;
        in_fifo_deq    = 1'b0;
        qp_mem_csb0    = 1'b1;
        qp_mem_web0    = 1'b1;
        qp_mem_addr0   = '0;
        qp_mem_wpatch0 = '0;
        busy           = 1'b1;
        load_done      = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                // Pop exactly when the FIFO head is valid; stall indefinitely otherwise.
                in_fifo_deq = in_fifo_rempty_n;
                if (in_fifo_rempty_n && last_word) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                qp_mem_csb0    = 1'b0;
                qp_mem_web0    = 1'b0;
                qp_mem_addr0   = patch_cnt_q;
                qp_mem_wpatch0 = patch_q;
                state_d        = last_patch ? DONE : FILL;
            end
            DONE: begin
                load_done = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: the patch register is a plain flop array, so it can be cleared by reset like any register.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt_q  <= '0;
            patch_cnt_q <= '0;
            patch_q     <= '0;
        end else begin
            if (state_q == IDLE && start) begin
                word_cnt_q  <= '0;
                patch_cnt_q <= '0;
            end
            if (in_fifo_deq) begin
                word_cnt_q <= last_word ? '0 : word_cnt_q + WCNT_WIDTH'(1);
                for (int k = 0; k < WORDS_PER_PATCH; k++) begin
                    if (word_cnt_q == WCNT_WIDTH'(k)) begin
                        patch_q[k*DATA_WIDTH +: DATA_WIDTH] <= in_fifo_rdata;
                    end
                end
            end
            // The counter holds at the last address so it never exceeds NUM_QUERYS-1.
            if (state_q == WRITE && !last_patch) begin
                patch_cnt_q <= patch_cnt_q + ADDR_WIDTH'(1);
            end
        end
    end

endmodule

// File: doc/qp_patch_loader.md
QP_PATCH_LOADER -- requirements
Module: qp_patch_loader

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 11, the width of one input FIFO word.
REQ-002 The block SHALL have parameter WORDS_PER_PATCH, default 5, the number of input words packed into one query patch.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 9, the query patch memory address width.
REQ-004 The block SHALL have parameter NUM_QUERYS, default 512, the number of patches written per load (2 to 2^ADDR_WIDTH).
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-008 The block SHALL have port start, input, 1 bit: single-cycle pulse that begins a load.
REQ-009 The block SHALL have port in_fifo_rdata, input, DATA_WIDTH bits: head word of the input FIFO (first-word-fall-through).
REQ-010 The block SHALL have port in_fifo_rempty_n, input, 1 bit: high when in_fifo_rdata is valid.
REQ-011 The block SHALL have port in_fifo_deq, output, 1 bit: pops the FIFO head this cycle.
REQ-012 The block SHALL have port qp_mem_csb0, output, 1 bit: active-low memory chip select.
REQ-013 The block SHALL have port qp_mem_web0, output, 1 bit: active-low memory write enable.
REQ-014 The block SHALL have port qp_mem_addr0, output, ADDR_WIDTH bits: patch write address.
REQ-015 The block SHALL have port qp_mem_wpatch0, output, DATA_WIDTH*WORDS_PER_PATCH bits (55 at defaults): patch write data.
REQ-016 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-017 The block SHALL have port load_done, output, 1 bit: single-cycle pulse when the last patch has been written.

Function
REQ-018 The block SHALL implement four states: IDLE, FILL, WRITE and DONE.
REQ-019 IDLE SHALL move to FILL on start=1; the word counter and the patch counter SHALL be 0 on entry to FILL.
REQ-020 In FILL, in_fifo_deq SHALL equal in_fifo_rempty_n, combinationally; it SHALL never be asserted while in_fifo_rempty_n=0.
REQ-021 Each dequeued word SHALL be stored at slice [k*DATA_WIDTH +: DATA_WIDTH] of the patch register, where k is the word counter (0..WORDS_PER_PATCH-1); word 0 occupies the LSBs.
REQ-022 The word counter SHALL increment only on a dequeue.
REQ-023 When the word counter is at WORDS_PER_PATCH-1 and a dequeue occurs, the word counter SHALL wrap to 0 and the state SHALL move to WRITE.
REQ-024 FILL SHALL wait indefinitely while the FIFO is empty, with no timeout.
REQ-025 WRITE SHALL last exactly one cycle, with qp_mem_csb0=0, qp_mem_web0=0, qp_mem_addr0=patch counter, qp_mem_wpatch0=patch register, and in_fifo_deq=0.
REQ-026 On leaving WRITE: if the patch counter equals NUM_QUERYS-1, the state SHALL move to DONE; otherwise the patch counter SHALL increment and the state SHALL return to FILL.
REQ-027 DONE SHALL last one cycle with load_done=1, then move to IDLE.
REQ-028 Latency SHALL be one cycle from the dequeue of the last word of a patch to its WRITE cycle; peak throughput SHALL be one patch per WORDS_PER_PATCH+1 cycles.
REQ-029 Outside WRITE, qp_mem_csb0 and qp_mem_web0 SHALL be 1, qp_mem_addr0 SHALL be 0 and qp_mem_wpatch0 SHALL be 0.
REQ-030 A start pulse SHALL be ignored in any state other than IDLE.
REQ-031 A start pulse arriving in the DONE cycle SHALL be lost.
REQ-032 Counter arithmetic SHALL be unsigned; the patch counter SHALL never exceed NUM_QUERYS-1.
REQ-033 in_fifo_deq SHALL be 0 in IDLE, WRITE and DONE.

Reset
REQ-034 When rst=1 at a clock edge, the block SHALL return to IDLE, clear both counters and the patch register, and drive busy=0, load_done=0, in_fifo_deq=0, qp_mem_csb0=1, qp_mem_web0=1, addr=0 and wpatch=0 from the next cycle.
REQ-035 Reset asserted mid-load SHALL abort the load with no further memory write and no load_done pulse.
REQ-036 Reset SHALL take priority over start.

Verification
REQ-037 Basic patch: start, then the FIFO presents words 0x001..0x005 back-to-back -> a single write to addr 0 with wpatch = {0x005,0x004,0x003,0x002,0x001}, one cycle after the 5th dequeue.
REQ-038 Full load: NUM_QUERYS=4 with 20 words continuously available -> writes to addr 0,1,2,3 spaced 6 cycles apart; load_done pulses once, the cycle after the addr-3 write; busy then falls.
REQ-039 Empty stalls: rempty_n deasserted for 3 cycles between words 2 and 3 -> deq stays 0 during the stall, no write occurs, and patch contents are unchanged versus the no-stall run.
REQ-040 Start while busy: a second start pulse during FILL -> ignored; the counters are not reset and the addresses continue in sequence.
REQ-041 Mid-load reset: rst asserted after the 7th word -> next cycle busy=0, csb0=1; a subsequent start writes its first patch to addr 0 built only from new words.
REQ-042 Boundary: a word arriving in the WRITE cycle (rempty_n=1) -> not dequeued until the following FILL cycle, and it becomes word 0 of the next patch.
